// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the IF stage and its F/D buffer.
//   - fetch_state_e : fetch FSM states
//   - JS_*          : jump_sel redirect codes driven by Decode
//   - *_HI/*_LO     : bit slices of an instruction's first word
//   - NOP_OPCODE    : opcode presented for an empty buffer slot
//   - is_two_word() : opcode carries a trailing immediate word
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_OP   = 2'd1,
    S_IMM  = 2'd2,
    S_VEC  = 2'd3
  } fetch_state_e;

  localparam logic [1:0] JS_SEQ = 2'b00;
  localparam logic [1:0] JS_BR  = 2'b01;
  localparam logic [1:0] JS_MEM = 2'b10;
  localparam logic [1:0] JS_INT = 2'b11;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 10;
  localparam int SRC_HI = 9;
  localparam int SRC_LO = 7;
  localparam int DST_HI = 6;
  localparam int DST_LO = 4;

  localparam logic [5:0] NOP_OPCODE = 6'b000000;

  function automatic logic is_two_word(input logic [5:0] opc);
    return (opc[5:4] == 2'b11);
  endfunction

endpackage

// File: rtl/fetch_stage_fd_buffer.sv
// fd_buffer: F/D pipeline register holding the Decode-facing fields.
// Priority per edge: rst (clear) > flush_i (NOP) > !enable_i (hold) > load.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i, enable_i   buffer controls from Decode
//   *_i                 fields to load (opcode/src/dst/imm/pc/interrupt tag)
//   *_o                 registered fields presented to Decode
module fd_buffer
  import fetch_stage_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         enable_i,
  input  logic [5:0]   opcode_i,
  input  logic [2:0]   src_i,
  input  logic [2:0]   dst_i,
  input  logic [W-1:0] imm_i,
  input  logic [W-1:0] pc_i,
  input  logic         intr_i,
  output logic [5:0]   opcode_o,
  output logic [2:0]   src_o,
  output logic [2:0]   dst_o,
  output logic [W-1:0] imm_o,
  output logic [W-1:0] pc_o,
  output logic         intr_o
);

  logic [5:0]   opcode_q;
  logic [2:0]   src_q;
  logic [2:0]   dst_q;
  logic [W-1:0] imm_q;
  logic [W-1:0] pc_q;
  logic         intr_q;

  // Buffer register: reset and flush both produce an all-zero NOP entry.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      opcode_q <= NOP_OPCODE;
      src_q    <= 3'd0;
      dst_q    <= 3'd0;
      imm_q    <= '0;
      pc_q     <= '0;
      intr_q   <= 1'b0;
    end else if (enable_i) begin
      opcode_q <= opcode_i;
      src_q    <= src_i;
      dst_q    <= dst_i;
      imm_q    <= imm_i;
      pc_q     <= pc_i;
      intr_q   <= intr_i;
    end else begin
      opcode_q <= opcode_q;
      src_q    <= src_q;
      dst_q    <= dst_q;
      imm_q    <= imm_q;
      pc_q     <= pc_q;
      intr_q   <= intr_q;
    end
  end

  assign opcode_o = opcode_q;
  assign src_o    = src_q;
  assign dst_o    = dst_q;
  assign imm_o    = imm_q;
  assign pc_o     = pc_q;
  assign intr_o   = intr_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch (PC, boot/interrupt vector loads, two-word
// assembly, interrupt latching) feeding the F/D buffer read by Decode.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr / imem_data    asynchronous-read instruction memory
//   pc_enable                0 holds PC and FSM
//   f_d_buffer_enable, flush F/D buffer hold / NOP insertion
//   jump_sel, branch_target, mem_target   PC redirects
//   interrupt_in             external interrupt request (level or pulse)
//   opcode/src/dst/imm/pc_out/interrupt   buffered instruction to Decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int W       = 16,
  parameter int ADDR_W  = 11,
  parameter int RST_VEC = 0,
  parameter int INT_VEC = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [W-1:0]      imem_data,
  input  logic              pc_enable,
  input  logic              f_d_buffer_enable,
  input  logic              flush,
  input  logic [1:0]        jump_sel,
  input  logic [W-1:0]      branch_target,
  input  logic [W-1:0]      mem_target,
  input  logic              interrupt_in,
  output logic [5:0]        opcode,
  output logic [2:0]        src,
  output logic [2:0]        dst,
  output logic [W-1:0]      imm,
  output logic [W-1:0]      pc_out,
  output logic              interrupt
);

  fetch_state_e state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  // Only opcode/src/dst of the first word are needed once the immediate arrives.
  logic [11:0]  hold_q, hold_d;
  logic [W-1:0] hold_pc_q, hold_pc_d;
  logic         pending_q, pending_d;

  logic         ld_valid;
  logic [5:0]   ld_opcode;
  logic [2:0]   ld_src;
  logic [2:0]   ld_dst;
  logic [W-1:0] ld_imm;
  logic [W-1:0] ld_pc;
  logic         deliver;

  // Memory address: vector words while loading a PC, otherwise the truncated PC.
  always_comb begin
    imem_addr = pc_q[ADDR_W-1:0];
    case (state_q)
      S_BOOT:  imem_addr = ADDR_W'(RST_VEC);
      S_VEC:   imem_addr = INT_VEC[ADDR_W-1:0];
      default: imem_addr = pc_q[ADDR_W-1:0];
    endcase
  end

  // Next-state logic: redirects take precedence over the sequential step and
  // discard any half-assembled two-word instruction.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    ld_valid  = 1'b0;
    ld_opcode = NOP_OPCODE;
    ld_src    = 3'd0;
    ld_dst    = 3'd0;
    ld_imm    = '0;
    ld_pc     = '0;
    if (pc_enable) begin
      if (jump_sel != JS_SEQ) begin
        case (jump_sel)
          JS_BR: begin
            pc_d    = branch_target;
            state_d = S_OP;
          end
          JS_MEM: begin
            pc_d    = mem_target;
            state_d = S_OP;
          end
          default: state_d = S_VEC;
        endcase
      end else begin
        case (state_q)
          S_BOOT, S_VEC: begin
            pc_d    = imem_data;
            state_d = S_OP;
          end
          S_OP: begin
            pc_d = pc_q + W'(1);
            if (is_two_word(imem_data[OPC_HI:OPC_LO])) begin
              hold_d    = imem_data[OPC_HI:DST_LO];
              hold_pc_d = pc_q;
              state_d   = S_IMM;
            end else begin
              ld_valid  = 1'b1;
              ld_opcode = imem_data[OPC_HI:OPC_LO];
              ld_src    = imem_data[SRC_HI:SRC_LO];
              ld_dst    = imem_data[DST_HI:DST_LO];
              ld_pc     = pc_q;
            end
          end
          S_IMM: begin
            pc_d      = pc_q + W'(1);
            ld_valid  = 1'b1;
            ld_opcode = hold_q[11:6];
            ld_src    = hold_q[5:3];
            ld_dst    = hold_q[2:0];
            ld_imm    = imem_data;
            ld_pc     = hold_pc_q;
            state_d   = S_OP;
          end
          default: state_d = S_BOOT;
        endcase
      end
    end else begin
      state_d = state_q;
    end
    // A pending interrupt rides only on a real instruction that reaches the buffer.
    deliver   = ld_valid & f_d_buffer_enable & ~flush;
    pending_d = interrupt_in | (pending_q & ~deliver);
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_BOOT;
      pc_q      <= '0;
      hold_q    <= 12'd0;
      hold_pc_q <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
      pending_q <= pending_d;
    end
  end

  fd_buffer #(.W(W)) u_fd_buffer (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush),
    .enable_i (f_d_buffer_enable),
    .opcode_i (ld_opcode),
    .src_i    (ld_src),
    .dst_i    (ld_dst),
    .imm_i    (ld_imm),
    .pc_i     (ld_pc),
    .intr_i   (ld_valid & pending_q),
    .opcode_o (opcode),
    .src_o    (src),
    .dst_o    (dst),
    .imm_o    (imm),
    .pc_o     (pc_out),
    .intr_o   (interrupt)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a program-walking reference model predicts
// the buffer contents and memory address after every edge; a monitor compares.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] imem_addr;
  logic [15:0] imem_data;
  logic        pc_enable = 1'b0;
  logic        f_d_buffer_enable = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  jump_sel = 2'b00;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] mem_target = 16'h0000;
  logic        interrupt_in = 1'b0;
  logic [5:0]  opcode;
  logic [2:0]  src;
  logic [2:0]  dst;
  logic [15:0] imm;
  logic [15:0] pc_out;
  logic        interrupt;

  logic [15:0] mem [0:2047];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc_enable(pc_enable), .f_d_buffer_enable(f_d_buffer_enable), .flush(flush),
    .jump_sel(jump_sel), .branch_target(branch_target), .mem_target(mem_target),
    .interrupt_in(interrupt_in), .opcode(opcode), .src(src), .dst(dst),
    .imm(imm), .pc_out(pc_out), .interrupt(interrupt)
  );

  typedef struct packed {
    logic [5:0]  opc;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        intr;
    logic [10:0] addr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: where the next word comes from and what Decode sees.
  logic [15:0] m_pc;
  int          m_vec;       // -1: fetching code, else memory word holding a new PC
  bit          m_half;      // first word of a two-word instruction captured
  logic [15:0] m_first;
  logic [15:0] m_first_pc;
  bit          m_pend;
  exp_t        m_buf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, record the expectation.
  task automatic cyc(input bit r, input bit pce, input bit fde, input bit fl,
                     input logic [1:0] js, input logic [15:0] bt, input logic [15:0] mt,
                     input bit irq);
    logic [15:0] word;
    bit          real_ld;
    exp_t        ent;
    exp_t        e;
    @(negedge clk);
    rst = r; pc_enable = pce; f_d_buffer_enable = fde; flush = fl;
    jump_sel = js; branch_target = bt; mem_target = mt; interrupt_in = irq;
    word    = (m_vec >= 0) ? mem[m_vec] : mem[m_pc[10:0]];
    ent     = '0;
    real_ld = 1'b0;
    if (r) begin
      m_pc = 16'h0000; m_vec = 0; m_half = 1'b0; m_pend = 1'b0; m_buf = '0;
    end else begin
      if (pce) begin
        if (js == 2'b01) begin
          m_pc = bt; m_vec = -1; m_half = 1'b0;
        end else if (js == 2'b10) begin
          m_pc = mt; m_vec = -1; m_half = 1'b0;
        end else if (js == 2'b11) begin
          m_vec = 1; m_half = 1'b0;
        end else if (m_vec >= 0) begin
          m_pc = word; m_vec = -1;
        end else if (m_half) begin
          ent.opc = m_first[15:10]; ent.src = m_first[9:7]; ent.dst = m_first[6:4];
          ent.imm = word; ent.pc = m_first_pc;
          real_ld = 1'b1; m_half = 1'b0; m_pc = m_pc + 16'd1;
        end else if (word[15:14] == 2'b11) begin
          m_half = 1'b1; m_first = word; m_first_pc = m_pc; m_pc = m_pc + 16'd1;
        end else begin
          ent.opc = word[15:10]; ent.src = word[9:7]; ent.dst = word[6:4];
          ent.imm = 16'h0000; ent.pc = m_pc;
          real_ld = 1'b1; m_pc = m_pc + 16'd1;
        end
      end
      if (fl) begin
        m_buf = '0;
      end else if (fde) begin
        m_buf = ent;
        m_buf.intr = real_ld && m_pend;
      end
      m_pend = irq || (m_pend && !(real_ld && fde && !fl));
    end
    e = m_buf;
    e.addr = (m_vec >= 0) ? m_vec[10:0] : m_pc[10:0];
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic seq();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("opcode",    32'(opcode),    32'(e.opc));
        chk("src",       32'(src),       32'(e.src));
        chk("dst",       32'(dst),       32'(e.dst));
        chk("imm",       32'(imm),       32'(e.imm));
        chk("pc_out",    32'(pc_out),    32'(e.pc));
        chk("interrupt", 32'(interrupt), 32'(e.intr));
        chk("imem_addr", 32'(imem_addr), 32'(e.addr));
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [15:0] p;
    int          r;
    for (int i = 0; i < 2048; i++) begin
      w = $urandom;
      if ((w[31:30]) == 2'b00) w[15:14] = 2'b11;
      mem[i] = w[15:0];
    end
    mem[0] = 16'h0020;
    mem[1] = 16'h0040;
    mem[16'h20] = 16'h0410;
    mem[16'h21] = 16'hC000;
    mem[16'h22] = 16'hBEEF;
    m_pc = 16'h0000; m_vec = 0; m_half = 1'b0; m_pend = 1'b0; m_buf = '0;
    m_first = 16'h0000; m_first_pc = 16'h0000;

    // Boot vector, then one-word and two-word instructions.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
    seq(); seq(); seq(); seq();

    // Stall three cycles, then flush while fetching continues.
    mem[m_pc[10:0]] = 16'h0C21;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0);
    seq();

    // Branch redirect abandons a half-assembled two-word instruction.
    mem[m_pc[10:0]] = 16'hC000;
    mem[16'h100] = 16'h0850;
    seq();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 16'h0100, 16'h0000, 1'b0);
    seq();

    // Interrupt pulse while a two-word instruction is fetched; tag only on it.
    p = m_pc;
    mem[p[10:0]] = 16'hC123;
    p = p + 16'd1; mem[p[10:0]] = 16'h1234;
    p = p + 16'd1; mem[p[10:0]] = 16'h0455;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1);
    seq(); seq();
    mem[1] = 16'h0300;
    mem[16'h300] = 16'h0C01;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0);
    seq(); seq();

    // Return via mem_target, then reset in the middle of a vector load.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 16'h0000, 16'h0500, 1'b0);
    seq();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
    seq(); seq();

    // PC wrap at 2^16 and address truncation.
    mem[11'h7FF] = 16'h0001;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 16'hFFFF, 16'h0000, 1'b0);
    seq(); seq(); seq();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      w = $urandom;
      if (r < 2) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, w[0]);
      end else if (r < 14) begin
        cyc(1'b0, 1'b0, 1'b0, (w[3:0] == 4'd0), 2'b00, 16'h0000, 16'h0000, (w[6:4] == 3'd0));
      end else begin
        cyc(1'b0, 1'b1, 1'b1, (w[3:0] == 4'd0),
            (w[9:7] == 3'd0) ? w[11:10] : 2'b00,
            $urandom, $urandom, (w[14:12] == 3'd0));
      end
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
